// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    SHOW_O,
    BLANK_O,
    SHOW_T,
    BLANK_T
  } state_t;

  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Positive-logic hex glyphs {g,f,e,d,c,b,a}, index 0 in the low slot.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to positive-logic 7-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller with a double-buffered
// write port. Optional macro SEG7_DIM_EN adds a 2-bit brightness input that
// shortens the lit part of each show window.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SHOW_CYCLES  = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
`ifdef SEG7_DIM_EN
  input  logic [1:0] brightness,
`endif
  output logic [6:0] seg_n,
  output logic       digit_sel,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(SHOW_CYCLES > BLANK_CYCLES ? SHOW_CYCLES : BLANK_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_HALF = CNT_W'(BLANK_CYCLES / 2);

  state_t           state, state_nx;
  logic [CNT_W-1:0] phase, phase_nx;
  logic             last;
  logic [7:0]       active, shadow;
  logic             shadow_full;
  logic [3:0]       digit_hex;
  logic [6:0]       glyph;
  logic             lit;
  logic [6:0]       seg_nx;
  logic             dsel_nx;

  assign wr_ready = ~shadow_full & ~RST;

  assign digit_hex = (state == SHOW_T) ? active[7:4] : active[3:0];

  seg7_hex_decode u_dec (
    .hex   (digit_hex),
    .glyph (glyph)
  );

`ifdef SEG7_DIM_EN
  logic [1:0]  bright_q;
  logic [31:0] lit_lim;

  // Brightness only changes at frame boundaries so a window is never split.
  always_ff @(posedge CLK) begin
    if (RST)             bright_q <= 2'd3;
    else if (frame_tick) bright_q <= brightness;
  end

  assign lit_lim = 32'({1'b0, bright_q} + 3'd1) * 32'(SHOW_CYCLES / 4);
  assign lit     = 32'(phase) < lit_lim;
`else
  assign lit = 1'b1;
`endif

  // Phase/state sequencing plus the next values of the registered pin drive.
  always_comb begin
    state_nx   = state;
    phase_nx   = phase + 1'b1;
    last       = 1'b0;
    seg_nx     = SEG_OFF_N;
    dsel_nx    = 1'b1;
    case (state)
      SHOW_O: begin
        last    = (phase == SHOW_LAST);
        dsel_nx = 1'b0;
        if (lit) seg_nx = ~glyph;
        if (last) state_nx = BLANK_O;
      end
      BLANK_O: begin
        last    = (phase == BLANK_LAST);
        // Switch digit select halfway through the dark gap.
        dsel_nx = (phase >= BLANK_HALF);
        if (last) state_nx = SHOW_T;
      end
      SHOW_T: begin
        last    = (phase == SHOW_LAST);
        dsel_nx = 1'b1;
        if (lit) seg_nx = ~glyph;
        if (last) state_nx = BLANK_T;
      end
      default: begin
        last    = (phase == BLANK_LAST);
        dsel_nx = (phase < BLANK_HALF);
        if (last) state_nx = SHOW_O;
      end
    endcase
    if (last) phase_nx = '0;
    // Disabled: park at the start of the tens gap so a restart runs a full gap.
    if (!en) begin
      state_nx = BLANK_T;
      phase_nx = '0;
      seg_nx   = SEG_OFF_N;
      dsel_nx  = 1'b1;
    end
  end

  assign frame_tick = ~RST & en & (state == BLANK_T) & last;

  // State and phase counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BLANK_T;
      phase <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  // Registered pin drive, one cycle behind the sequencer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_n     <= SEG_OFF_N;
      digit_sel <= 1'b1;
    end else begin
      seg_n     <= seg_nx;
      digit_sel <= dsel_nx;
    end
  end

  // Double buffer: writes land in shadow, shadow moves to active at the boundary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      active      <= 8'h00;
      shadow      <= 8'h00;
      shadow_full <= 1'b0;
    end else begin
      if (frame_tick && shadow_full) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end
      if (wr_valid && wr_ready) begin
        shadow      <= wr_data;
        shadow_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int S = 8;
  localparam int B = 4;
  localparam int F = 2 * (S + B);
`ifdef SEG7_DIM_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [1:0] bright_in;
  logic [6:0] seg_n;
  logic       digit_sel;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 CLK = ~CLK;

  seg7_scan_ctrl #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
`ifdef SEG7_DIM_EN
    .brightness (bright_in),
`endif
    .seg_n      (seg_n),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within a 24-cycle frame, 0 = first ones-show cycle.
  int         pos;
  logic [7:0] m_active, m_shadow;
  bit         m_full;
  int         m_bright;

  task automatic model_reset();
    pos      = F - B;
    m_active = 8'h00;
    m_shadow = 8'h00;
    m_full   = 1'b0;
    m_bright = 3;
  endtask

  initial begin
    bit         exp_ready, exp_tick, lit, en_hold, prev_dsel;
    logic [6:0] exp_seg;
    logic       exp_dsel;
    int         q;

    RST = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; bright_in = 2'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_digit_sel", digit_sel, 1'b1);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    model_reset();
    en_hold   = 1'b1;
    prev_dsel = 1'b1;

    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge CLK);
      RST = (cyc >= 1500 && cyc < 1503);
      if (cyc >= 1000 && cyc % 20 == 0) en_hold = ($urandom_range(0, 3) != 0);
      en = (cyc >= 600 && cyc < 650) ? 1'b0 : en_hold;
      wr_valid = ($urandom_range(0, 9) == 0);
      wr_data  = 8'($urandom);
      if (cyc % 37 == 0) bright_in = 2'($urandom_range(0, 3));
      #1;
      exp_ready = !RST && !m_full;
      exp_tick  = !RST && en && (pos == F - 1);
      chk("wr_ready", wr_ready, exp_ready);
      chk("frame_tick", frame_tick, exp_tick);

      // Pin drive expected after this edge, from the current frame position.
      exp_seg  = 7'h7F;
      exp_dsel = 1'b1;
      if (!RST && en) begin
        if (pos < S) begin
          lit = !DIM || (pos < (m_bright + 1) * S / 4);
          exp_dsel = 1'b0;
          if (lit) exp_seg = ~glyph_tab[m_active[3:0]];
        end else if (pos < S + B) begin
          q = pos - S;
          exp_dsel = (q >= B / 2);
        end else if (pos < 2 * S + B) begin
          q = pos - S - B;
          lit = !DIM || (q < (m_bright + 1) * S / 4);
          if (lit) exp_seg = ~glyph_tab[m_active[7:4]];
        end else begin
          q = pos - 2 * S - B;
          exp_dsel = (q < B / 2);
        end
      end

      @(posedge CLK);
      if (RST) begin
        model_reset();
      end else begin
        if (exp_tick && m_full) begin
          m_active = m_shadow;
          m_full   = 1'b0;
        end
        if (wr_valid && exp_ready) begin
          m_shadow = wr_data;
          m_full   = 1'b1;
        end
        if (exp_tick) m_bright = int'(bright_in);
        pos = en ? (pos + 1) % F : F - B;
      end
      #1;
      chk("seg_n", seg_n, exp_seg);
      chk("digit_sel", digit_sel, exp_dsel);
      if (digit_sel !== prev_dsel) chk("dsel_toggle_dark", seg_n, 7'h7F);
      prev_dsel = digit_sel;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
